// File: rtl/cw_group_buf.sv
// Ping-pong frame buffer: serial coded bits are written into one L-bit bank while the
// other, completed bank is read out as GW-bit codeword groups.
module cw_group_buf #(
    parameter int GW        = 3,
    parameter int NG        = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_di,
    input  logic          i_di_vld,
    input  logic          i_di_sop,
    output logic          o_di_rdy,
    output logic          o_ovf,
    output logic [GW-1:0] o_do,
    output logic          o_do_vld,
    input  logic          i_do_rdy,
    output logic          o_do_last
);
    localparam int L    = GW * NG;
    localparam int WI_W = $clog2(L);
    localparam int GI_W = $clog2(NG);
    localparam logic [WI_W-1:0] WIDX_LAST = WI_W'(L - 1);
    localparam logic [GI_W-1:0] GIDX_LAST = GI_W'(NG - 1);

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    logic [L-1:0]    r_bank [2];
    logic [1:0]      r_full;
    logic            r_wbank;
    logic            r_rbank;
    logic [WI_W-1:0] r_widx;
    logic [GI_W-1:0] r_gidx;
    state_t          r_state;
    logic [GW-1:0]   r_do;
    logic            r_do_vld;
    logic            r_do_last;

    state_t          w_state_nxt;
    logic            w_acc;
    logic            w_wr_last;
    logic            w_load;
    logic            w_fill;
    logic            w_rd_done;
    logic [WI_W-1:0] w_wptr;
    logic [WI_W-1:0] w_rbase;
    logic [GW-1:0]   w_grp;
    logic [1:0]      w_set;
    logic [1:0]      w_clr;

    // raw[0] is the first-received bit of the group
    function automatic logic [GW-1:0] map_grp(input logic [GW-1:0] raw);
        logic [GW-1:0] rev;
        for (int k = 0; k < GW; k++) rev[GW-1-k] = raw[k];
        return MSB_FIRST ? rev : raw;
    endfunction

    assign o_di_rdy  = !r_full[r_wbank];
    assign o_ovf     = i_di_vld && !o_di_rdy;
    assign w_acc     = i_di_vld && o_di_rdy;
    assign w_wptr    = i_di_sop ? '0 : r_widx;
    assign w_wr_last = w_acc && (w_wptr == WIDX_LAST);

    always_ff @(posedge clk) begin
        if (w_acc) r_bank[r_wbank][w_wptr] <= i_di;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_widx  <= '0;
            r_wbank <= 1'b0;
        end else if (w_acc) begin
            if (w_wr_last) begin
                r_widx  <= '0;
                r_wbank <= !r_wbank;
            end else begin
                r_widx  <= w_wptr + 1'b1;
            end
        end
    end

    // A bank being set and a bank being cleared in one cycle are always different banks
    assign w_set = w_wr_last ? (2'b01 << r_wbank) : 2'b00;
    assign w_clr = w_rd_done ? (2'b01 << r_rbank) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_full <= 2'b00;
        else     r_full <= (r_full & ~w_clr) | w_set;
    end

    assign w_load  = !r_do_vld || i_do_rdy;
    assign w_rbase = WI_W'(r_gidx) * WI_W'(GW);
    assign w_grp   = map_grp(r_bank[r_rbank][w_rbase +: GW]);

    always_comb begin
        w_state_nxt = r_state;
        w_fill      = 1'b0;
        w_rd_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load && r_full[r_rbank]) begin
                    w_fill      = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_load) begin
                    w_fill = 1'b1;
                    if (r_gidx == GIDX_LAST) begin
                        w_rd_done = 1'b1;
                        if (!r_full[!r_rbank]) w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rbank   <= 1'b0;
            r_gidx    <= '0;
            r_do      <= '0;
            r_do_vld  <= 1'b0;
            r_do_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rd_done) begin
                r_rbank <= !r_rbank;
                r_gidx  <= '0;
            end else if (w_fill) begin
                r_gidx  <= r_gidx + 1'b1;
            end
            if (w_load) begin
                r_do_vld  <= w_fill;
                r_do_last <= w_rd_done;
                if (w_fill) r_do <= w_grp;
            end
        end
    end

    assign o_do      = r_do;
    assign o_do_vld  = r_do_vld;
    assign o_do_last = r_do_last;

endmodule

// File: tb/tb_cw_group_buf.sv
// Scoreboard bench for cw_group_buf: three instances (3x32 MSB-first, 3x32 LSB-first,
// 2x4 MSB-first) share one input stream; a frame-level model predicts every group.
module tb_cw_group_buf;
    logic clk = 1'b0;
    logic rst;
    logic di, di_vld, di_sop, do_rdy;
    logic rdy0, rdy1, rdy2, ovf0, ovf1, ovf2;
    logic v0, v1, v2, l0, l1, l2;
    logic [2:0] d0, d1;
    logic [1:0] d2;

    always #5 clk = ~clk;

    cw_group_buf #(.GW(3), .NG(32), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .i_di(di), .i_di_vld(di_vld), .i_di_sop(di_sop),
        .o_di_rdy(rdy0), .o_ovf(ovf0), .o_do(d0), .o_do_vld(v0), .i_do_rdy(do_rdy),
        .o_do_last(l0));
    cw_group_buf #(.GW(3), .NG(32), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .i_di(di), .i_di_vld(di_vld), .i_di_sop(di_sop),
        .o_di_rdy(rdy1), .o_ovf(ovf1), .o_do(d1), .o_do_vld(v1), .i_do_rdy(do_rdy),
        .o_do_last(l1));
    cw_group_buf #(.GW(2), .NG(4), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst(rst), .i_di(di), .i_di_vld(di_vld), .i_di_sop(di_sop),
        .o_di_rdy(rdy2), .o_ovf(ovf2), .o_do(d2), .o_do_vld(v2), .i_do_rdy(do_rdy),
        .o_do_last(l2));

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int   errors = 0;
    int   checks = 0;
    int   GWv[3]  = '{3, 3, 2};
    int   NGv[3]  = '{32, 32, 4};
    bit   MSBv[3] = '{1'b1, 1'b0, 1'b1};
    bit   cur_bits[3][96];
    int   cur_len[3] = '{0, 0, 0};
    int   ngrp[3] = '{0, 0, 0};
    int   ovf_cnt0 = 0;
    bit   held0 = 1'b0;
    logic [2:0] hd0;
    logic hl0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void push_exp(int id, logic [7:0] d, bit last);
        exp_t e;
        e.d = d;
        e.last = last;
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    // Frame-level model: collect L accepted bits, then emit NG groups in order
    function automatic void model_bit(int id, bit b, bit sop);
        int flen;
        logic [7:0] v;
        flen = GWv[id] * NGv[id];
        if (sop) cur_len[id] = 0;
        cur_bits[id][cur_len[id]] = b;
        cur_len[id]++;
        if (cur_len[id] == flen) begin
            for (int g = 0; g < NGv[id]; g++) begin
                v = '0;
                for (int k = 0; k < GWv[id]; k++) begin
                    if (MSBv[id]) v[GWv[id]-1-k] = cur_bits[id][GWv[id]*g+k];
                    else          v[k]           = cur_bits[id][GWv[id]*g+k];
                end
                push_exp(id, v, g == NGv[id] - 1);
            end
            cur_len[id] = 0;
        end
    endfunction

    function automatic void flush();
        q0.delete();
        q1.delete();
        q2.delete();
        cur_len = '{0, 0, 0};
    endfunction

    task automatic take(input int id, input logic [7:0] d, input logic l);
        exp_t e;
        bit   ok;
        ok = 1'b1;
        case (id)
            0:       if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
            1:       if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
            default: if (q2.size() == 0) ok = 1'b0; else e = q2.pop_front();
        endcase
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL extra_group%0d: got do=%0h with nothing expected", id, d);
        end else begin
            chk($sformatf("do_inst%0d", id), {24'd0, d}, {24'd0, e.d});
            chk($sformatf("last_inst%0d", id), {31'd0, l}, {31'd0, e.last});
        end
        ngrp[id]++;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            held0 = 1'b0;
        end else begin
            chk("ovf_inst0", {31'd0, ovf0}, {31'd0, di_vld && !rdy0});
            chk("ovf_inst2", {31'd0, ovf2}, {31'd0, di_vld && !rdy2});
            ovf_cnt0 += int'(ovf0);
            if (held0) begin
                chk("hold_vld", {31'd0, v0}, 32'd1);
                chk("hold_do", {29'd0, d0}, {29'd0, hd0});
                chk("hold_last", {31'd0, l0}, {31'd0, hl0});
            end
            held0 = v0 && !do_rdy;
            hd0 = d0;
            hl0 = l0;
            if (v0 && do_rdy) take(0, {5'd0, d0}, l0);
            if (v1 && do_rdy) take(1, {5'd0, d1}, l1);
            if (v2 && do_rdy) take(2, {6'd0, d2}, l2);
        end
    end

    task automatic cyc(input bit vld, input bit b, input bit sop);
        di_vld = vld;
        di     = b;
        di_sop = sop;
        if (vld && rdy0) model_bit(0, b, sop);
        if (vld && rdy1) model_bit(1, b, sop);
        if (vld && rdy2) model_bit(2, b, sop);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        di_vld = 1'b0;
        di_sop = 1'b0;
        do_rdy = 1'b1;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", {31'd0, n < 3000}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, s2, lows, oc;
        rst = 1'b1; di = 1'b0; di_vld = 1'b0; di_sop = 1'b0; do_rdy = 1'b0;
        #1;
        chk("rst_vld", {31'd0, v0 | v1 | v2}, 32'd0);
        chk("rst_do", {24'd0, d0, d1, d2}, 32'd0);
        chk("rst_last", {31'd0, l0 | l1 | l2}, 32'd0);
        chk("rst_ovf", {31'd0, ovf0 | ovf1 | ovf2}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rdy_after_rst", {29'd0, rdy0, rdy1, rdy2}, 32'd7);

        // One frame of 1,0,0 with exact first-group latency
        do_rdy = 1'b1;
        s0 = ngrp[0]; s1 = ngrp[1]; s2 = ngrp[2];
        for (int i = 0; i < 96; i++) cyc(1'b1, (i % 3) == 0, i == 0);
        di_vld = 1'b0;
        @(negedge clk);
        chk("lat_early", {31'd0, v0}, 32'd0);
        @(negedge clk);
        chk("lat_first", {31'd0, v0}, 32'd1);
        chk("first_do_msb", {29'd0, d0}, 32'd4);
        chk("first_do_lsb", {29'd0, d1}, 32'd1);
        @(posedge clk);
        #1;
        drain();
        chk("grp_cnt0", ngrp[0] - s0, 32);
        chk("grp_cnt1", ngrp[1] - s1, 32);
        chk("grp_cnt2", ngrp[2] - s2, 48);

        // Three back-to-back frames, output never stalled
        s0 = ngrp[0]; lows = 0; oc = ovf_cnt0;
        for (int i = 0; i < 288; i++) begin
            if (!rdy0) lows++;
            cyc(1'b1, 1'($urandom), (i % 96) == 0);
        end
        drain();
        chk("stream_rdy_lows", lows, 0);
        chk("stream_ovf", ovf_cnt0 - oc, 0);
        chk("stream_grps", ngrp[0] - s0, 96);

        // Output stalled: both banks fill, the 193rd bit is dropped
        do_rdy = 1'b0;
        oc = ovf_cnt0; s0 = ngrp[0];
        for (int i = 0; i < 192; i++) cyc(1'b1, 1'($urandom), (i % 96) == 0);
        chk("full_rdy", {31'd0, rdy0}, 32'd0);
        di_vld = 1'b1; di = 1'b1; di_sop = 1'b0;
        @(negedge clk);
        chk("drop_ovf", {31'd0, ovf0}, 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("drop_ovf_cnt", ovf_cnt0 - oc, 1);
        chk("still_full", {31'd0, rdy0}, 32'd0);
        drain();
        chk("stall_grps", ngrp[0] - s0, 64);

        // Restart mid-frame: only the new frame is delivered
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'($urandom), i == 0);
        for (int i = 0; i < 95; i++) cyc(1'b1, 1'($urandom), i == 0);
        chk("sop_no_early", {31'd0, v0}, 32'd0);
        cyc(1'b1, 1'($urandom), 1'b0);
        drain();

        // Reset in the middle of the output of a frame
        for (int i = 0; i < 96; i++) cyc(1'b1, 1'($urandom), i == 0);
        di_vld = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("pre_rst_vld", {31'd0, v0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_vld", {31'd0, v0}, 32'd0);
        chk("rst_mid_do", {29'd0, d0}, 32'd0);
        flush();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rdy", {31'd0, rdy0}, 32'd1);
        chk("rst_no_stale", {31'd0, v0}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 96; i++) cyc(1'b1, 1'($urandom), i == 0);
        drain();

        // Random traffic with random backpressure and occasional restarts
        for (int i = 0; i < 3000; i++) begin
            bit vv;
            do_rdy = ($urandom % 10) < 6;
            vv = ($urandom % 10) < 7;
            cyc(vv, 1'($urandom), vv && (($urandom % 150) == 0));
        end
        drain();
        chk("end_idle", {31'd0, v0 | v1 | v2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
